// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing defaults (640x480@60) and helpers for vga_timing_gen and its axis counters.
package vga_timing_gen_pkg;

  localparam int DEF_H_DISPLAY     = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_PULSE  = 96;
  localparam int DEF_H_BACK_PORCH  = 48;
  localparam int DEF_V_DISPLAY     = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_PULSE  = 2;
  localparam int DEF_V_BACK_PORCH  = 33;
  localparam int DEF_CNT_W         = 10;
  localparam int DEF_FRAME_CNT_W   = 8;
  localparam int DEF_TILE_SHIFT    = 4;

  function automatic int axis_total(input int display, input int fp, input int sync, input int bp);
    return display + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 on step, decodes active region and sync pulse.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int   DISPLAY  = DEF_H_DISPLAY,
  parameter int   FP       = DEF_H_FRONT_PORCH,
  parameter int   SYNC     = DEF_H_SYNC_PULSE,
  parameter int   BP       = DEF_H_BACK_PORCH,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CNT_W    = DEF_CNT_W
) (
  input  logic             clock_25,
  input  logic             reset,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int TOTAL = axis_total(DISPLAY, FP, SYNC, BP);

  // One extra bit so the sync end bound may equal 2**CNT_W without overflow.
  localparam logic [CNT_W:0] LAST_X   = (CNT_W+1)'(TOTAL - 1);
  localparam logic [CNT_W:0] DISP_X   = (CNT_W+1)'(DISPLAY);
  localparam logic [CNT_W:0] SSTART_X = (CNT_W+1)'(DISPLAY + FP);
  localparam logic [CNT_W:0] SEND_X   = (CNT_W+1)'(DISPLAY + FP + SYNC);

  logic [CNT_W:0] cnt_x;
  logic           in_pulse;

  assign cnt_x    = {1'b0, cnt};
  assign wrap     = (cnt_x == LAST_X);
  assign active   = (cnt_x < DISP_X);
  assign in_pulse = (cnt_x >= SSTART_X) && (cnt_x < SEND_X);
  assign sync     = in_pulse ? SYNC_POL : ~SYNC_POL;

  always_ff @(posedge clock_25) begin
    if (!reset) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with registered, mutually aligned outputs.
// Optional tile coordinates are built when VGA_TILE_COORD_EN is defined.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_DISPLAY     = DEF_H_DISPLAY,
  parameter int   H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int   H_SYNC_PULSE  = DEF_H_SYNC_PULSE,
  parameter int   H_BACK_PORCH  = DEF_H_BACK_PORCH,
  parameter int   V_DISPLAY     = DEF_V_DISPLAY,
  parameter int   V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int   V_SYNC_PULSE  = DEF_V_SYNC_PULSE,
  parameter int   V_BACK_PORCH  = DEF_V_BACK_PORCH,
  parameter logic HSYNC_POL     = 1'b0,
  parameter logic VSYNC_POL     = 1'b0,
  parameter int   CNT_W         = DEF_CNT_W,
  parameter int   FRAME_CNT_W   = DEF_FRAME_CNT_W,
  parameter int   TILE_SHIFT    = DEF_TILE_SHIFT
) (
  input  logic                   clock_25,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   display_area,
  output logic [CNT_W-1:0]       X,
  output logic [CNT_W-1:0]       Y,
  output logic                   line_start,
  output logic                   frame_tik,
  output logic [FRAME_CNT_W-1:0] frame_count
`ifdef VGA_TILE_COORD_EN
  ,
  output logic [CNT_W-TILE_SHIFT-1:0] tile_x,
  output logic [CNT_W-TILE_SHIFT-1:0] tile_y
`endif
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, h_active, h_sync_c;
  logic v_wrap_unused, v_active, v_sync_c;
  logic disp_c, line_c, tik_c;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FP(H_FRONT_PORCH), .SYNC(H_SYNC_PULSE), .BP(H_BACK_PORCH),
    .SYNC_POL(HSYNC_POL), .CNT_W(CNT_W)
  ) u_h_axis (
    .clock_25(clock_25), .reset(reset), .step(enable),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_active), .sync(h_sync_c)
  );

  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FP(V_FRONT_PORCH), .SYNC(V_SYNC_PULSE), .BP(V_BACK_PORCH),
    .SYNC_POL(VSYNC_POL), .CNT_W(CNT_W)
  ) u_v_axis (
    .clock_25(clock_25), .reset(reset), .step(enable & h_wrap),
    .cnt(v_cnt), .wrap(v_wrap_unused), .active(v_active), .sync(v_sync_c)
  );

  assign disp_c = h_active & v_active;
  assign line_c = (h_cnt == '0);
  assign tik_c  = line_c && (v_cnt == CNT_W'(V_DISPLAY));

  // Output stage: decoded from the pre-increment counter state, so every output
  // describes the same pixel one cycle later.
  always_ff @(posedge clock_25) begin
    if (!reset) begin
      h_sync       <= ~HSYNC_POL;
      v_sync       <= ~VSYNC_POL;
      display_area <= 1'b0;
      X            <= '0;
      Y            <= '0;
      line_start   <= 1'b0;
      frame_tik    <= 1'b0;
      frame_count  <= '0;
    end else if (enable) begin
      h_sync       <= h_sync_c;
      v_sync       <= v_sync_c;
      display_area <= disp_c;
      X            <= disp_c ? h_cnt : '0;
      Y            <= disp_c ? v_cnt : '0;
      line_start   <= line_c;
      frame_tik    <= tik_c;
      if (tik_c) frame_count <= frame_count + 1'b1;
    end else begin
      line_start <= 1'b0;
      frame_tik  <= 1'b0;
    end
  end

`ifdef VGA_TILE_COORD_EN
  always_ff @(posedge clock_25) begin
    if (!reset) begin
      tile_x <= '0;
      tile_y <= '0;
    end else if (enable) begin
      tile_x <= disp_c ? h_cnt[CNT_W-1:TILE_SHIFT] : '0;
      tile_y <= disp_c ? v_cnt[CNT_W-1:TILE_SHIFT] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-enable bench for vga_timing_gen against a pixel-index reference model.
module tb_vga_timing_gen;

  localparam int HD = 8, HFP = 2, HSW = 3, HBP = 1;
  localparam int VD = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int CW = 6, FW = 4, TS = 2;
  localparam int HT = HD + HFP + HSW + HBP;
  localparam int VT = VD + VFP + VSW + VBP;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset, enable;
  logic h_sync, v_sync, display_area, line_start, frame_tik;
  logic [CW-1:0] X, Y;
  logic [FW-1:0] frame_count;
`ifdef VGA_TILE_COORD_EN
  logic [CW-TS-1:0] tile_x, tile_y;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSW), .H_BACK_PORCH(HBP),
    .V_DISPLAY(VD), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSW), .V_BACK_PORCH(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(CW), .FRAME_CNT_W(FW), .TILE_SHIFT(TS)
  ) dut (
    .clock_25(clk), .reset(reset), .enable(enable),
    .h_sync(h_sync), .v_sync(v_sync), .display_area(display_area),
    .X(X), .Y(Y), .line_start(line_start), .frame_tik(frame_tik),
    .frame_count(frame_count)
`ifdef VGA_TILE_COORD_EN
    , .tile_x(tile_x), .tile_y(tile_y)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: p = number of enabled pixels since reset release.
  longint p;
  longint e_hs, e_vs, e_da, e_x, e_y, e_ls, e_ft, e_fc;

  function automatic longint frames_ticked(input longint pix);
    longint first = longint'(VD) * HT;
    if (pix < first) return 0;
    return ((pix - first) / FT + 1) % (1 << FW);
  endfunction

  task automatic step_cycle();
    longint h, v;
    @(posedge clk);
    if (!reset) begin
      p = 0;
      e_hs = 0; e_vs = 0; e_da = 0; e_x = 0; e_y = 0; e_ls = 0; e_ft = 0; e_fc = 0;
    end else if (enable) begin
      h = p % HT;
      v = (p / HT) % VT;
      e_da = (h < HD && v < VD) ? 1 : 0;
      e_x  = e_da ? h : 0;
      e_y  = e_da ? v : 0;
      e_hs = (h >= HD + HFP && h < HD + HFP + HSW) ? 1 : 0;
      e_vs = (v >= VD + VFP && v < VD + VFP + VSW) ? 1 : 0;
      e_ls = (h == 0) ? 1 : 0;
      e_ft = (h == 0 && v == VD) ? 1 : 0;
      e_fc = frames_ticked(p);
      p++;
    end else begin
      e_ls = 0;
      e_ft = 0;
    end
    #1;
    chk("h_sync", h_sync, e_hs);
    chk("v_sync", v_sync, e_vs);
    chk("display_area", display_area, e_da);
    chk("X", X, e_x);
    chk("Y", Y, e_y);
    chk("line_start", line_start, e_ls);
    chk("frame_tik", frame_tik, e_ft);
    chk("frame_count", frame_count, e_fc);
`ifdef VGA_TILE_COORD_EN
    chk("tile_x", tile_x, e_x >> TS);
    chk("tile_y", tile_y, e_y >> TS);
`endif
  endtask

  bit seen_wrap;
  logic [FW-1:0] prev_fc;

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) step_cycle();

    reset = 1'b1;
    repeat (3 * FT) step_cycle();

    repeat (1500) begin
      enable = ($urandom_range(0, 3) != 0);
      step_cycle();
    end

    // Mid-frame reset with random enable; reset must win.
    reset = 1'b0;
    repeat (5) begin
      enable = $urandom_range(0, 1) == 1;
      step_cycle();
    end
    chk("rst_h_sync", h_sync, 0);
    chk("rst_frame_count", frame_count, 0);
    reset = 1'b1;
    enable = 1'b1;
    step_cycle();
    chk("rel_display_area", display_area, 1);
    chk("rel_line_start", line_start, 1);
    chk("rel_X", X, 0);
    chk("rel_Y", Y, 0);

    seen_wrap = 1'b0;
    prev_fc = frame_count;
    repeat (3000) begin
      enable = ($urandom_range(0, 3) != 0);
      step_cycle();
      if (prev_fc == {FW{1'b1}} && frame_count == '0) seen_wrap = 1'b1;
      prev_fc = frame_count;
    end
    chk("frame_count_wrapped", seen_wrap, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
